// File: rtl/window_count_if.sv
// Interface bundling the control, data and status signals of the window
// count detector. clk and rstb stay as plain ports on the detector itself.
//   master : drives enable, in_valid, serial_pattern, mode, threshold, hit_clr
//            and observes pattern_detected, ones_count, window_full, hit_count
//   slave  : the detector side (directions reversed)
// WIN and HIT_W must match the parameters of the detector it connects to.
interface window_count_if #(
  parameter int WIN   = 3,
  parameter int HIT_W = 16
);
  localparam int CNT_W = $clog2(WIN + 1);

  logic             enable;
  logic             in_valid;
  logic             serial_pattern;
  logic [1:0]       mode;
  logic [CNT_W-1:0] threshold;
  logic             hit_clr;
  logic             pattern_detected;
  logic [CNT_W-1:0] ones_count;
  logic             window_full;
  logic [HIT_W-1:0] hit_count;

  modport master (
    output enable, in_valid, serial_pattern, mode, threshold, hit_clr,
    input  pattern_detected, ones_count, window_full, hit_count
  );

  modport slave (
    input  enable, in_valid, serial_pattern, mode, threshold, hit_clr,
    output pattern_detected, ones_count, window_full, hit_count
  );
endinterface

// File: rtl/window_count_detector.sv
// Serial window detector. Keeps the last WIN accepted bits and pulses
// pattern_detected for one cycle after each accepted sample whose full window
// holds exactly / at least / at most `threshold` ones (selected by mode).
// Ports:
//   clk   : clock, rising edge
//   rstb  : synchronous active-high reset
//   bus   : window_count_if.slave -- enable, in_valid, serial_pattern, mode,
//           threshold, hit_clr in; pattern_detected, ones_count,
//           window_full, hit_count out
module window_count_detector #(
  parameter int WIN   = 3,
  parameter int HIT_W = 16
) (
  input  logic           clk,
  input  logic           rstb,
  window_count_if.slave  bus
);
  localparam int CNT_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  logic [WIN-1:0]   window;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] ones;
  logic             full;
  logic             det;
  logic [HIT_W-1:0] hits;

  logic             accept;
  logic             oldest;
  logic [CNT_W-1:0] ones_next;
  logic [CNT_W-1:0] fill_next;
  logic             full_next;
  logic             cmp_hit;
  logic             det_next;

  always_comb begin
    accept    = bus.enable & bus.in_valid;
    // The bit falling out of the window only counts once the window is full;
    // before that the top of the shift register is still empty.
    oldest    = full ? window[WIN-1] : 1'b0;
    ones_next = ones + CNT_W'(bus.serial_pattern) - CNT_W'(oldest);
    fill_next = (fill == WIN_C) ? fill : fill + CNT_W'(1);
    full_next = (fill_next == WIN_C);
    case (bus.mode)
      2'b01:   cmp_hit = (ones_next >= bus.threshold);
      2'b10:   cmp_hit = (ones_next <= bus.threshold);
      default: cmp_hit = (ones_next == bus.threshold);
    endcase
    // Partial windows never detect, even in at-most mode.
    det_next  = accept & full_next & cmp_hit;
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      window <= '0;
      fill   <= '0;
      ones   <= '0;
      full   <= 1'b0;
      det    <= 1'b0;
    end else if (!bus.enable) begin
      window <= '0;
      fill   <= '0;
      ones   <= '0;
      full   <= 1'b0;
      det    <= 1'b0;
    end else if (bus.in_valid) begin
      window <= {window[WIN-2:0], bus.serial_pattern};
      fill   <= fill_next;
      ones   <= ones_next;
      full   <= full_next;
      det    <= det_next;
    end else begin
      det    <= 1'b0;
    end
  end

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rstb) begin
      hits <= '0;
    end else if (bus.hit_clr) begin
      hits <= '0;
    end else if (det_next && (hits != HIT_MAX)) begin
      hits <= hits + HIT_W'(1);
    end
  end

  assign bus.pattern_detected = det;
  assign bus.ones_count       = ones;
  assign bus.window_full      = full;
  assign bus.hit_count        = hits;
endmodule

// File: tb/tb_window_count_detector.sv
// Bench for window_count_detector: three instances (WIN=3, WIN=8, and WIN=3
// with a 2-bit hit counter) share one stimulus stream; each is compared
// every cycle against a queue-based reference of the last WIN accepted bits.
module tb_window_count_detector;
  logic       clk;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic       ser;
  logic [1:0] mode;
  logic       hit_clr;
  logic [1:0] thr_a;
  logic [3:0] thr_b;
  logic [1:0] thr_c;

  int n_checks;
  int n_errors;

  window_count_if #(.WIN(3), .HIT_W(16)) bus_a ();
  window_count_if #(.WIN(8), .HIT_W(16)) bus_b ();
  window_count_if #(.WIN(3), .HIT_W(2))  bus_c ();

  assign bus_a.enable = enable;  assign bus_b.enable = enable;  assign bus_c.enable = enable;
  assign bus_a.in_valid = in_valid;  assign bus_b.in_valid = in_valid;  assign bus_c.in_valid = in_valid;
  assign bus_a.serial_pattern = ser;  assign bus_b.serial_pattern = ser;  assign bus_c.serial_pattern = ser;
  assign bus_a.mode = mode;  assign bus_b.mode = mode;  assign bus_c.mode = mode;
  assign bus_a.hit_clr = hit_clr;  assign bus_b.hit_clr = hit_clr;  assign bus_c.hit_clr = hit_clr;
  assign bus_a.threshold = thr_a;
  assign bus_b.threshold = thr_b;
  assign bus_c.threshold = thr_c;

  window_count_detector #(.WIN(3), .HIT_W(16)) dut_a (.clk(clk), .rstb(rst), .bus(bus_a));
  window_count_detector #(.WIN(8), .HIT_W(16)) dut_b (.clk(clk), .rstb(rst), .bus(bus_b));
  window_count_detector #(.WIN(3), .HIT_W(2))  dut_c (.clk(clk), .rstb(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state: accepted bits since the last flush, newest at the back
  bit hist_a[$];
  bit hist_b[$];
  bit hist_c[$];
  int exp_det  [3];
  int exp_ones [3];
  int exp_full [3];
  int exp_hits [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input int i, input int win, input int hmax, input int k);
    bit q[$];
    int cnt;
    bit hit;
    case (i)
      0:       q = hist_a;
      1:       q = hist_b;
      default: q = hist_c;
    endcase
    hit = 1'b0;
    if (rst || !enable) begin
      q.delete();
    end else if (in_valid) begin
      q.push_back(ser);
      if (q.size() > win) void'(q.pop_front());
      cnt = 0;
      foreach (q[j]) cnt += int'(q[j]);
      if (q.size() == win) begin
        case (mode)
          2'd1:    hit = (cnt >= k);
          2'd2:    hit = (cnt <= k);
          default: hit = (cnt == k);
        endcase
      end
    end
    cnt = 0;
    foreach (q[j]) cnt += int'(q[j]);
    exp_ones[i] = cnt;
    exp_full[i] = (q.size() == win) ? 1 : 0;
    exp_det[i]  = hit ? 1 : 0;
    if (rst)                                exp_hits[i] = 0;
    else if (hit_clr)                       exp_hits[i] = 0;
    else if (hit && exp_hits[i] < hmax)     exp_hits[i]++;
    case (i)
      0:       hist_a = q;
      1:       hist_b = q;
      default: hist_c = q;
    endcase
  endtask

  task automatic step();
    model_update(0, 3, 65535, int'(thr_a));
    model_update(1, 8, 65535, int'(thr_b));
    model_update(2, 3, 3,     int'(thr_c));
    @(posedge clk);
    #1;
    check("a_det",  int'(bus_a.pattern_detected), exp_det[0]);
    check("a_ones", int'(bus_a.ones_count),       exp_ones[0]);
    check("a_full", int'(bus_a.window_full),      exp_full[0]);
    check("a_hits", int'(bus_a.hit_count),        exp_hits[0]);
    check("b_det",  int'(bus_b.pattern_detected), exp_det[1]);
    check("b_ones", int'(bus_b.ones_count),       exp_ones[1]);
    check("b_full", int'(bus_b.window_full),      exp_full[1]);
    check("b_hits", int'(bus_b.hit_count),        exp_hits[1]);
    check("c_det",  int'(bus_c.pattern_detected), exp_det[2]);
    check("c_ones", int'(bus_c.ones_count),       exp_ones[2]);
    check("c_full", int'(bus_c.window_full),      exp_full[2]);
    check("c_hits", int'(bus_c.hit_count),        exp_hits[2]);
  endtask

  task automatic feed(input bit b, input bit v);
    enable   = 1'b1;
    in_valid = v;
    ser      = b;
    step();
  endtask

  task automatic flush();
    enable   = 1'b0;
    in_valid = 1'b0;
    step();
    enable   = 1'b1;
  endtask

  task automatic set_k(input int k);
    thr_a = 2'(k);
    thr_b = 4'(k);
    thr_c = 2'(k);
  endtask

  initial begin
    bit [6:0] s1;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; ser = 1'b0;
    mode = 2'd0; hit_clr = 1'b0;
    set_k(2);
    foreach (exp_hits[i]) exp_hits[i] = 0;
    step();
    check("reset_det",  int'(bus_a.pattern_detected), 0);
    check("reset_hits", int'(bus_a.hit_count), 0);
    rst = 1'b0;

    // exact K=2, bits 1,1,0,1,1,1,0 every cycle
    s1 = 7'b1101110;
    for (int i = 6; i >= 0; i--) feed(s1[i], 1'b1);
    check("p1_hits", int'(bus_a.hit_count), 4);

    // same stream, in_valid low on alternate cycles
    flush();
    hit_clr = 1'b1; feed(1'b0, 1'b0); hit_clr = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      feed(s1[i], 1'b1);
      feed(1'b1, 1'b0);
      check("p2_idle_det", int'(bus_a.pattern_detected), 0);
    end
    check("p2_hits", int'(bus_a.hit_count), 4);

    // at-most K=0: partial window then flush, then a full all-zero window
    mode = 2'd2; set_k(0);
    flush();
    feed(1'b0, 1'b1); feed(1'b0, 1'b1);
    check("p3_partial", int'(bus_a.pattern_detected), 0);
    flush();
    feed(1'b0, 1'b1);
    check("p3_fresh_full", int'(bus_a.window_full), 0);
    feed(1'b0, 1'b1); feed(1'b0, 1'b1);
    check("p3_det",  int'(bus_a.pattern_detected), 1);
    check("p3_full", int'(bus_a.window_full), 1);

    // WIN=8 at-least K=6: 1 x8 then 0 x3
    mode = 2'd1; set_k(6);
    flush();
    for (int i = 0; i < 8; i++) feed(1'b1, 1'b1);
    check("p4_ones8", int'(bus_b.ones_count), 8);
    for (int i = 0; i < 3; i++) feed(1'b0, 1'b1);
    check("p4_ones5", int'(bus_b.ones_count), 5);
    check("p4_nodet", int'(bus_b.pattern_detected), 0);

    // 2-bit hit counter saturation, then clear against a detect
    mode = 2'd0; set_k(1);
    flush();
    hit_clr = 1'b1; feed(1'b0, 1'b0); hit_clr = 1'b0;
    for (int r = 0; r < 4; r++) begin
      feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b0, 1'b1);
    end
    check("p5_sat", int'(bus_c.hit_count), 3);
    hit_clr = 1'b1; feed(1'b1, 1'b1); hit_clr = 1'b0;
    check("p5_clr_det", int'(bus_c.pattern_detected), 1);
    check("p5_clr", int'(bus_c.hit_count), 0);

    // reset mid-stream with enable and valid high
    mode = 2'd2; set_k(3);
    feed(1'b1, 1'b1); feed(1'b0, 1'b1);
    rst = 1'b1; feed(1'b1, 1'b1); rst = 1'b0;
    check("p6_rst_ones", int'(bus_a.ones_count), 0);
    check("p6_rst_hits", int'(bus_b.hit_count), 0);
    feed(1'b1, 1'b1); feed(1'b1, 1'b1);
    check("p6_partial", int'(bus_a.pattern_detected), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 19) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      ser      = 1'($urandom);
      hit_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        thr_a = 2'($urandom);
        thr_b = 4'($urandom);
        thr_c = 2'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/window_count_detector.md
Name: window_count_detector

Overview:
Parametrised serial window detector, the next generation of the 2-of-3 pattern detector. It tracks the last WIN accepted bits of a serial stream and flags each accepted sample whose window holds a qualifying number of ones: exactly, at least, or at most a runtime threshold. It adds input qualification (in_valid), a live ones count, a window-full flag and a saturating hit counter for the status block.

Parameters:
WIN, 3, window length in samples (2..64)
CNT_W, $clog2(WIN+1), width of ones count and threshold (derived; do not override)
HIT_W, 16, width of saturating hit counter

Ports:
clk  input  1  clock, all logic on rising edge
rstb  input  1  synchronous active-high reset
enable  input  1  block enable; low flushes window state
in_valid  input  1  serial_pattern qualifier
serial_pattern  input  1  serial data bit
mode  input  2  00 exact, 01 at-least, 10 at-most, 11 reserved (treated as exact)
threshold  input  CNT_W  comparison value K
hit_clr  input  1  clears hit_count
pattern_detected  output  1  registered one-cycle detect pulse
ones_count  output  CNT_W  ones in current window (registered)
window_full  output  1  WIN samples accepted since last flush
hit_count  output  HIT_W  saturating count of detect pulses

Behaviour:
- Reset (rstb=1 at clk edge): window shift register, fill counter, ones_count, window_full, pattern_detected, hit_count all 0. Reset overrides every other input.
- Accept: sample accepted at edge when enable=1 and in_valid=1. No backpressure.
- On accept: window <= {window[WIN-2:0], serial_pattern}. ones_next = ones_count + serial_pattern - (window_full ? window[WIN-1] : 0). Fill counter increments, saturating at WIN. window_full goes high on the edge that accepts the WIN-th sample.
- Detect: on accept, pattern_detected <= full_next && cmp(ones_next, threshold). cmp: exact ones==K; at-least ones>=K; at-most ones<=K. Comparison is unsigned at CNT_W bits. Latency is one cycle: the pulse appears in the cycle after the sample edge.
- Partial window (fill < WIN) never detects, in every mode, including at-most.
- No accept (in_valid=0, enable=1): window, count and fill hold. pattern_detected <= 0, so every pulse is exactly one cycle per qualifying sample.
- enable=0: window, fill, ones_count, window_full and pattern_detected <= 0 (flush to idle). hit_count holds. The first sample after re-enable starts a fresh window.
- threshold and mode are sampled at each accept edge; a change takes effect on the next accepted sample. K>WIN gives no detects in exact and at-least modes, and a detect on every full window in at-most mode.
- hit_count increments on each edge where pattern_detected is loaded with 1. It saturates at 2^HIT_W-1. hit_clr=1 sets it to 0 and wins over a simultaneous increment.
- Invariant: ones_count == popcount(window) at all times.

Test Plan:
- WIN=3, exact, K=2, enable=1, valid every cycle, bits 1,1,0,1,1,1,0 -> pattern_detected pulses after samples 3,4,5,7 (windows 110,101,011,110); none after 6 (111); hit_count=4.
- Same stream with in_valid low on alternate cycles -> same pulses in sample order, each 1 cycle wide; pattern_detected=0 in idle cycles; ones_count holds while in_valid=0.
- WIN=3, at-most, K=0, bits 0,0 then enable=0 then 0 -> no pulse (window never fills); after re-enable, bits 0,0,0 -> pulse after third; window_full rises on that same edge.
- WIN=8, at-least, K=6, bits 1 x8 then 0 x3 -> ones_count 8,7,6,5; pulses on samples 8,9,10; none on 11.
- HIT_W=2, exact, K=1, stream repeating 1,0,0 after fill -> hit_count saturates at 3. Then hit_clr asserted on an edge with a detect -> hit_count=0.
- Assert rstb mid-stream with enable=1 and in_valid=1 -> all outputs 0 next cycle; the following WIN-1 accepted samples produce no pulse.
